md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the pipelined MIPS core. It owns the HI and LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Produces the Busy indication that the hazard/stall unit combines with Start to stall HI/LO-class instructions in ID.
- mfhi and mflo read the hi and lo outputs directly through the EX result mux.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_if.sv | 32 +++
 rtl/md_calc.sv | 49 ++++
 rtl/md_unit.sv | 102 ++++++++++
 tb/tb_md_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op encodings and widths shared by the multiply/divide unit
package md_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 4;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    // Multi-cycle ops occupy the unit; everything else finishes in one edge or is a no-op.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_if.sv
// rtl/md_if.sv - EX-stage request/result bundle of the md unit; MD_CANCEL_EN adds the cancel qualifier
interface md_if;
    import md_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic            busy;
    logic [31:0]     hi;
    logic [31:0]     lo;
`ifdef MD_CANCEL_EN
    logic            cancel;
`endif

    modport master (
        output start, op, a, b,
`ifdef MD_CANCEL_EN
        output cancel,
`endif
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
`ifdef MD_CANCEL_EN
        input  cancel,
`endif
        output busy, hi, lo
    );

endinterface

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational mult/div datapath producing {hi, lo} and a divide-by-zero flag
module md_calc
    import md_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    output logic [63:0]     res,
    output logic            div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_f;
    logic [31:0] rem_f;

    // The low 64 bits of a sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; this also makes 0x80000000 / -1 wrap to 0x80000000.
    assign sdiv     = (op == MD_DIV);
    assign num      = (sdiv && a[31]) ? (~a + 32'd1) : a;
    assign den      = (sdiv && b[31]) ? (~b + 32'd1) : b;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign quo      = num / den_safe;
    assign rem      = num % den_safe;
    assign quo_f    = (sdiv && (a[31] ^ b[31])) ? (~quo + 32'd1) : quo;
    assign rem_f    = (sdiv && a[31]) ? (~rem + 32'd1) : rem;

    assign div0 = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    always_comb begin
        res = 64'd0;
        case (op)
            MD_MULT:         res = prod_s;
            MD_MULTU:        res = prod_u;
            MD_DIV, MD_DIVU: res = {rem_f, quo_f};
            default:         res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning HI/LO; MD_CANCEL_EN gates start with cancel
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             launch;
    logic             finish;
    logic [63:0]      calc_res;
    logic             calc_div0;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    md_calc u_calc (
        .op   (md.op),
        .a    (md.a),
        .b    (md.b),
        .res  (calc_res),
        .div0 (calc_div0)
    );

`ifdef MD_CANCEL_EN
    assign accept = md.start && !md.cancel;
`else
    assign accept = md.start;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_long_op(md.op)) begin
                    launch     = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result is computed at launch from the captured operands, held until the count expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (launch) begin
            pend_hi <= calc_res[63:32];
            pend_lo <= calc_res[31:0];
            pend_wr <= !calc_div0;
            cnt     <= is_mult_op(md.op) ? MULT_CNT : DIV_CNT;
        end else if (state == ST_IDLE) begin
            if (accept && (md.op == MD_MTHI)) hi_q <= md.a;
            if (accept && (md.op == MD_MTLO)) lo_q <= md.a;
        end else begin
            cnt <= cnt - CNT_W'(1);
            if (finish && pend_wr) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end
    end

    assign md.busy = (state == ST_BUSY);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit; MD_CANCEL_EN enables the cancel checks
module tb_md_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: every busy falling edge is a completion and retires one scoreboard entry.
    initial begin
        int   run;
        logic prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (bus.busy) run++;
                if (!bus.busy && prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_completion: got hi=%h lo=%h expected no completion", bus.hi, bus.lo);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_cycles"}, 32'(run), 32'(e.cycles));
                        check({e.name, "_hi"}, bus.hi, e.hi);
                        check({e.name, "_lo"}, bus.lo, e.lo);
                    end
                    run = 0;
                end
                prev = bus.busy;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.start && bus.busy)
            $display("note: start while busy at %0t (protocol violation, must be ignored)", $time);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic long_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int cycles, input logic [31:0] hi, input logic [31:0] lo,
                           input string name);
        exp_q.push_back('{cycles, hi, lo, name});
        issue(op, a, b);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef MD_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);

        long_op(MD_MULT,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg");
        wait_idle("mult_neg");
        long_op(MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, "multu");
        wait_idle("multu");
        long_op(MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000, "mult_minmin");
        wait_idle("mult_minmin");
        long_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_negnum");
        wait_idle("div_negnum");
        long_op(MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negden");
        wait_idle("div_negden");
        long_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
        wait_idle("div_ovf");

        issue(MD_MTHI, 32'h12345678, 32'd0);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        check("mthi_hi", bus.hi, 32'h12345678);
        check("mthi_lo", bus.lo, 32'h80000000);

        long_op(MD_DIVU, 32'd100, 32'd0, 10, 32'h12345678, 32'h80000000, "divu_zero");
        wait_idle("divu_zero");

        issue(MD_MTLO, 32'hCAFEF00D, 32'd0);
        check("mtlo_lo", bus.lo, 32'hCAFEF00D);
        issue(3'd6, 32'h11111111, 32'h22222222);
        check("nop_busy", {31'd0, bus.busy}, 32'd0);
        check("nop_hi", bus.hi, 32'h12345678);
        check("nop_lo", bus.lo, 32'hCAFEF00D);

        // Abort: reset lands in the third busy cycle of a divu.
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_late_hi", bus.hi, 32'd0);
        check("abort_late_lo", bus.lo, 32'd0);

        // Starts during busy must be ignored; the original mult lands on schedule.
        long_op(MD_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12, "mult_ignore");
        @(posedge clk);
        #1;
        issue(MD_MTLO, 32'hDEAD0000, 32'd0);
        check("busy_mtlo_lo", bus.lo, 32'd0);
        issue(MD_MULT, 32'd5, 32'd5);
        wait_idle("mult_ignore");

        long_op(MD_MULTU, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, "multu_b2b");
        wait_idle("multu_b2b");
        long_op(MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu_b2b");
        wait_idle("divu_b2b");

`ifdef MD_CANCEL_EN
        bus.cancel = 1'b1;
        issue(MD_MTLO, 32'h00000055, 32'd0);
        check("cancel_mtlo_lo", bus.lo, 32'd14);
        issue(MD_DIVU, 32'd9, 32'd3);
        check("cancel_divu_busy", {31'd0, bus.busy}, 32'd0);
        bus.cancel = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
